// File: rtl/wb_drain_ctrl_pkg.sv
// wb_drain_ctrl_pkg: write-buffer entry layout and drain FSM encoding
package wb_drain_ctrl_pkg;
  localparam int WB_ENTRY_W = 68;
  localparam int WB_ADDR_MSB = 67;
  localparam int WB_ADDR_LSB = 36;
  localparam int WB_DATA_MSB = 35;
  localparam int WB_DATA_LSB = 4;
  localparam int WB_BE_MSB = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, WR_REQ = 2'd1, RD_REQ = 2'd2} state_t;
endpackage

// File: rtl/wb_drain_ctrl.sv
// wb_drain_ctrl: drains the store write buffer to memory and serves refill reads after the drain
module wb_drain_ctrl
  import wb_drain_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_empty_in,
  input  logic [WB_ENTRY_W-1:0] wb_data_in,
  output logic                  wb_pop_en_out,
  input  logic                  rd_req_in,
  input  logic [ADDR_W-1:0]     rd_addr_in,
  output logic [DATA_W-1:0]     rd_data_out,
  output logic                  rd_done_out,
  output logic                  mem_req_out,
  output logic                  mem_we_out,
  output logic [ADDR_W-1:0]     mem_addr_out,
  output logic [DATA_W-1:0]     mem_wdata_out,
  output logic [3:0]            mem_be_out,
  input  logic                  mem_ack_in,
  input  logic [DATA_W-1:0]     mem_rdata_in,
  output logic                  busy_out,
  output logic                  err_timeout_out
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t st;
  logic [7:0] cnt;
  logic take_wr;
  logic take_rd;
  always_comb begin
    take_wr = st == IDLE && !wb_empty_in;
    take_rd = st == IDLE && wb_empty_in && rd_req_in && !rd_done_out;
  end
  // head entry is combinational, so the pop pulses in the same cycle the fields are captured
  assign wb_pop_en_out = take_wr && !rst;
  assign busy_out = st != IDLE || !wb_empty_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      mem_req_out <= 1'b0;
      mem_we_out <= 1'b0;
      mem_addr_out <= '0;
      mem_wdata_out <= '0;
      mem_be_out <= '0;
      rd_data_out <= '0;
      rd_done_out <= 1'b0;
      err_timeout_out <= 1'b0;
    end else begin
      rd_done_out <= 1'b0;
      if (take_wr) begin
        st <= WR_REQ;
        cnt <= '0;
        mem_req_out <= 1'b1;
        mem_we_out <= 1'b1;
        mem_addr_out <= wb_data_in[WB_ADDR_MSB:WB_ADDR_LSB];
        mem_wdata_out <= wb_data_in[WB_DATA_MSB:WB_DATA_LSB];
        mem_be_out <= wb_data_in[WB_BE_MSB:0];
      end else if (take_rd) begin
        st <= RD_REQ;
        cnt <= '0;
        mem_req_out <= 1'b1;
        mem_we_out <= 1'b0;
        mem_addr_out <= rd_addr_in;
        mem_wdata_out <= '0;
        mem_be_out <= 4'hF;
      end else if (st != IDLE) begin
        if (mem_ack_in) begin
          st <= IDLE;
          mem_req_out <= 1'b0;
          mem_we_out <= 1'b0;
          if (st == RD_REQ) begin
            rd_data_out <= mem_rdata_in;
            rd_done_out <= 1'b1;
          end
        end else begin
          cnt <= cnt == 8'hFF ? cnt : cnt + 8'd1;
          if (cnt == TMO - 8'd1) err_timeout_out <= 1'b1;
        end
      end
    end
  end
endmodule
